// File: rtl/serializer_p_if.sv
// serializer_p_if: parallel-offer / serial-output bundle for serializer_p.
interface serializer_p_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] P_DATA;
  logic              Data_Valid;
  logic              msb_first;
  logic              ser_en;
  logic              ready;
  logic              busy;
  logic              ser_data;
  logic              ser_done;
  modport master (output P_DATA, Data_Valid, msb_first, ser_en, input ready, busy, ser_data, ser_done);
  modport slave  (input P_DATA, Data_Valid, msb_first, ser_en, output ready, busy, ser_data, ser_done);
endinterface

// File: rtl/serializer_p.sv
// serializer_p: parallel-to-serial shifter with per-word bit order.
// Define SER_DBUF_EN to add a one-word holding buffer for gapless back-to-back words.
module serializer_p #(
  parameter int DATA_W = 8
) (
  input logic           CLK,
  input logic           RST,
  serializer_p_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ord_q, ord_d;
  logic              done_q, done_d;
  logic              accept, last;
`ifdef SER_DBUF_EN
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_ord_q, hold_ord_d;
  logic              hold_full_q, hold_full_d;
  assign bus.ready = !hold_full_q;
`else
  assign bus.ready = (state_q == IDLE);
`endif
  assign accept       = bus.Data_Valid && bus.ready;
  assign last         = (state_q == ACTIVE) && bus.ser_en && (cnt_q == CNT_W'(DATA_W - 1));
  assign bus.busy     = (state_q == ACTIVE);
  assign bus.ser_done = done_q;
  assign bus.ser_data = (state_q == ACTIVE) ? (ord_q ? shreg_q[DATA_W-1] : shreg_q[0]) : 1'b1;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    done_d  = 1'b0;
`ifdef SER_DBUF_EN
    hold_d      = hold_q;
    hold_ord_d  = hold_ord_q;
    hold_full_d = hold_full_q;
`endif
    if (state_q == IDLE) begin
      if (accept) begin
        shreg_d = bus.P_DATA;
        ord_d   = bus.msb_first;
        cnt_d   = '0;
        state_d = ACTIVE;
      end
    end else begin
      if (bus.ser_en) begin
        shreg_d = ord_q ? shreg_q << 1 : shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
      end
      if (last) begin
        done_d = 1'b1;
        cnt_d  = '0;
`ifdef SER_DBUF_EN
        // Chain the next word straight in so the stream has no idle gap.
        if (hold_full_q) begin
          shreg_d     = hold_q;
          ord_d       = hold_ord_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          shreg_d = bus.P_DATA;
          ord_d   = bus.msb_first;
        end else state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef SER_DBUF_EN
      else if (accept) begin
        hold_d      = bus.P_DATA;
        hold_ord_d  = bus.msb_first;
        hold_full_d = 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ord_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SER_DBUF_EN
      hold_q      <= '0;
      hold_ord_q  <= 1'b0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ord_q   <= ord_d;
      done_q  <= done_d;
`ifdef SER_DBUF_EN
      hold_q      <= hold_d;
      hold_ord_q  <= hold_ord_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end
endmodule

// File: tb/tb_serializer_p.sv
// tb_serializer_p: random and directed checks of serializer_p against a bit-queue model.
module tb_serializer_p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic last_ser, last_done;
  always #5 clk = ~clk;
  serializer_p_if #(.DATA_W(8))  b8();
  serializer_p_if #(.DATA_W(12)) b12();
  serializer_p #(.DATA_W(8))  u8  (.CLK(clk), .RST(rst_n), .bus(b8));
  serializer_p #(.DATA_W(12)) u12 (.CLK(clk), .RST(rst_n), .bus(b12));
  // Model: the current word as a queue of remaining bits, plus an optional pending word.
  bit       m_active;
  bit       m_done;
  bit       m_bits[$];
  bit [8:0] m_pend[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_ready();
`ifdef SER_DBUF_EN
    return m_pend.size() == 0;
`else
    return !m_active;
`endif
  endfunction
  task automatic m_load(input bit [8:0] w);
    m_bits.delete();
    for (int k = 0; k < 8; k++) m_bits.push_back(w[8] ? w[7-k] : w[k]);
    m_active = 1'b1;
  endtask
  task automatic m_edge(input bit dv, input bit [7:0] d, input bit m, input bit en);
    bit acc;
    acc = dv && m_ready();
    m_done = 1'b0;
    if (m_active && en) begin
      void'(m_bits.pop_front());
      if (m_bits.size() == 0) begin
        m_done = 1'b1;
        if (m_pend.size() != 0) m_load(m_pend.pop_front());
        else if (acc) begin
          m_load({m, d});
          acc = 1'b0;
        end else m_active = 1'b0;
      end
    end
    if (acc) begin
      if (!m_active) m_load({m, d});
      else m_pend.push_back({m, d});
    end
  endtask
  task automatic step(input bit dv, input bit [7:0] d, input bit m, input bit en);
    @(negedge clk);
    b8.Data_Valid = dv;
    b8.P_DATA     = d;
    b8.msb_first  = m;
    b8.ser_en     = en;
    #1;
    last_ser  = b8.ser_data;
    last_done = b8.ser_done;
    chk("ready", 32'(b8.ready), 32'(m_ready()));
    chk("busy", 32'(b8.busy), 32'(m_active));
    chk("ser_data", 32'(b8.ser_data), m_active ? 32'(m_bits[0]) : 32'd1);
    chk("ser_done", 32'(b8.ser_done), 32'(m_done));
    m_edge(dv, d, m, en);
    @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    b8.Data_Valid = 1'b0;
    b8.ser_en     = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("rst_ready", 32'(b8.ready), 32'd1);
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_ser_data", 32'(b8.ser_data), 32'd1);
    chk("rst_done", 32'(b8.ser_done), 32'd0);
    m_active = 1'b0;
    m_done   = 1'b0;
    m_bits.delete();
    m_pend.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask
  initial begin
    logic [7:0]  a5;
    logic [11:0] c35;
    int          dones;
    a5  = 8'hA5;
    c35 = 12'hC35;
    b8.Data_Valid = 1'b0; b8.P_DATA = '0; b8.msb_first = 1'b0; b8.ser_en = 1'b0;
    b12.Data_Valid = 1'b0; b12.P_DATA = '0; b12.msb_first = 1'b0; b12.ser_en = 1'b0;
    do_reset();
    // A5 LSB-first, ser_en every cycle
    step(1, 8'hA5, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 8'h00, 1, 1);
      chk("a5_bit", 32'(last_ser), 32'(a5[k]));
    end
    step(0, 8'h00, 0, 0);
    chk("a5_done", 32'(last_done), 32'd1);
    step(0, 8'h00, 0, 0);
    // Offer while busy: dropped without the buffer
    step(1, 8'h3C, 1, 0);
    step(1, 8'hFF, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 8'h00, 0, 1);
    // Back-to-back words
    step(1, 8'h0F, 1, 1);
    step(1, 8'hF0, 0, 1);
    for (int k = 0; k < 18; k++) step(0, 8'h00, 0, 1);
    // Reset after the 3rd ser_en of a word
    step(1, 8'h5A, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 8'h00, 0, 1);
    do_reset();
    step(0, 8'h00, 0, 0);
    step(1, 8'h3C, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 8'h00, 0, 1);
    // ser_en in IDLE is ignored
    for (int k = 0; k < 5; k++) step(0, 8'h00, 0, 1);
    step(1, 8'h01, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 8'h00, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(($urandom % 3) == 0, 8'($urandom), 1'($urandom), (i < 300) ? (($urandom % 4) != 0) : (($urandom % 3) == 0));
    end
    // 12-bit word C35 MSB-first, ser_en every third cycle
    @(negedge clk);
    b12.P_DATA = 12'hC35; b12.msb_first = 1'b1; b12.Data_Valid = 1'b1; b12.ser_en = 1'b0;
    @(posedge clk);
    dones = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      b12.Data_Valid = 1'b0;
      b12.msb_first  = 1'b0;
      b12.ser_en     = (i % 3) == 2;
      #1;
      chk("c35_bit", 32'(b12.ser_data), 32'(c35[11 - i / 3]));
      chk("c35_busy", 32'(b12.busy), 32'd1);
      if (b12.ser_done) dones++;
      @(posedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b12.ser_en = 1'b0;
      #1;
      if (b12.ser_done) dones++;
      if (i == 0) chk("c35_done_pulse", 32'(b12.ser_done), 32'd1);
      if (i == 1) chk("c35_idle", 32'(b12.busy), 32'd0);
      @(posedge clk);
    end
    chk("c35_done_count", 32'(dones), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
